// File: rtl/shift_sequencer.sv
// shift_sequencer: command-driven WIDTH-bit register bank (load / shift left / shift right / rotate right).
// Latency: load completes in 1 edge; an N-step shift completes N+1 edges after acceptance (done pulse follows).
// Backpressure: start is only honoured while busy=0; starts seen during RUN or DONE are dropped, not queued.
//
// Ports:
//   clock, reset   posedge clock, asynchronous active-low reset (clears q and aborts any command)
//   start          command strobe, sampled only on an idle edge
//   op             00 load, 01 shift left, 10 shift right, 11 rotate right
//   count          number of shift/rotate steps (0 completes immediately, ignored for load)
//   din            parallel load data
//   ser_in         serial bit shifted in by shift left/right, sampled every RUN edge
//   q              register bank contents
//   ser_out        bit that would leave on the next shift (MSB for shift left, LSB otherwise)
//   busy, done     busy while a command is in flight; done pulses for one cycle at completion
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] din,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ROR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       op_r;
  logic [1:0]       op_nxt;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] remaining_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] q_step;

  // One step of the latched operation applied to the current bank value.
  // Only consumed in RUN, where op_r is never a load.
  always_comb begin
    q_step = q;
    case (op_r)
      OP_SHL:  q_step = {q[WIDTH-2:0], ser_in};
      OP_SHR:  q_step = {ser_in, q[WIDTH-1:1]};
      OP_ROR:  q_step = {q[0], q[WIDTH-1:1]};
      default: q_step = q;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt     = state;
    op_nxt        = op_r;
    remaining_nxt = remaining;
    q_nxt         = q;
    case (state)
      IDLE: begin
        if (start) begin
          op_nxt        = op;
          remaining_nxt = count;
          if (op == OP_LOAD) begin
            q_nxt     = din;
            state_nxt = DONE;
          end else if (count == '0) begin
            // Zero-length shift: complete without touching q.
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        q_nxt         = q_step;
        remaining_nxt = remaining - CNT_W'(1);
        if (remaining == CNT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Start is deliberately not sampled here; the next command can
        // only be accepted from IDLE one edge later.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_r      <= OP_LOAD;
      remaining <= '0;
      q         <= '0;
    end else begin
      state     <= state_nxt;
      op_r      <= op_nxt;
      remaining <= remaining_nxt;
      q         <= q_nxt;
    end
  end

  // Status outputs decode registered state only, so they cannot glitch.
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign ser_out = (op_r == OP_SHL) ? q[WIDTH-1] : q[0];

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Owns a WIDTH-bit bank of D flip-flops and sequences operations on it: parallel load, N-step shift left, N-step shift right, and N-step rotate right.
- Serves as the command-driven controller for the lab's register datapath.
- Uses a start/busy/done handshake. One command executes at a time.
- Provides serial in/out for chaining to other register blocks.

Parameters:
- WIDTH, 8, width of the register bank q and of din.
- CNT_W, 4, width of the count input (max shifts per command = 2^CNT_W-1).

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  command strobe; sampled only when busy=0.
- op  input  2  command: 00 load, 01 shift left, 10 shift right, 11 rotate right.
- count  input  CNT_W  number of shift steps; ignored for load.
- din  input  WIDTH  parallel load data.
- ser_in  input  1  serial input bit for shift left and shift right.
- q  output  WIDTH  register bank contents.
- ser_out  output  1  bit that would leave on the next shift.
- busy  output  1  high while a command is in progress (state != IDLE).
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: reset=0 clears everything immediately, independent of clock: q=0, state=IDLE, busy=0, done=0, remaining=0, latched op op_r=00. An in-flight command is aborted and no done is issued. The first command is accepted on the first posedge after reset returns to 1.
- FSM states: IDLE, RUN, DONE. busy=(state!=IDLE). done=(state==DONE). Both are registered-state decodes, glitch-free.
- IDLE, start=1 at edge E0: op and count are latched (op_r, remaining).
  - op=00: q<=din at E0; next state DONE.
  - op!=00, count=0: q unchanged; next state DONE.
  - op!=00, count>0: next state RUN.
- RUN: exactly one step per edge, with remaining<=remaining-1.
  - When remaining==1, perform the last step and go to DONE.
  - A count of N gives shifts at edges E1..EN. done is high for the cycle after EN. The state returns to IDLE at EN+1, which is the earliest edge at which a new start is accepted.
- DONE: transitions to IDLE unconditionally. A start sampled in DONE is ignored.
- start while busy=1: ignored. Command inputs need only be valid at the accepting edge.
- Step operations (q = current value):
  - shift left: q<={q[WIDTH-2:0], ser_in}
  - shift right: q<={ser_in, q[WIDTH-1:1]}
  - rotate right: q<={q[0], q[WIDTH-1:1]}; ser_in is ignored.
- ser_out (combinational from registers): q[WIDTH-1] when op_r=01, otherwise q[0]. op_r holds its value in IDLE until the next accepted command.
- ser_in is sampled on every RUN edge; it may change between steps.
- Load latency: 1 edge (q updated at E0, done during cycle E0..E1).
- Shift latency: N+1 edges from acceptance to done.

Test Plan:
- Reset pulse low mid-cycle with q nonzero -> q=0, busy=0, done=0 before the next clock edge; no done afterwards.
- op=00, din=8'hA5, start 1 cycle -> q=A5 after E0; busy=1 and done=1 for exactly one cycle; busy=0 after E1.
- q=A5, op=01, count=3, ser_in=1 -> q steps 4B, 97, 2F on E1..E3; ser_out before E1 =1; done one cycle after E3; busy high 4 cycles.
- q=F0, op=10, count=4, ser_in=0 -> q=0F after E4. Then op=11, count=8 on q=A5 -> q=A5 after 8 rotations, intermediate D2 after the first.
- op=01, count=0 -> done the cycle after acceptance, q unchanged, no RUN cycles. start held high continuously -> a new command is accepted only on edges where busy=0.
- op=11, count=5 on A5, reset low after 2 rotations -> q=0, state IDLE, done never asserted; a subsequent load of 3C works normally.
